// File: rtl/s32x_sdr_arb.sv
// Multi-master SDRAM arbiter: SH-2 style masters share one SDRAM port through an
// IDLE/ISSUE/BUSY/DONE sequence with round-robin or fixed-priority grant and BUSY timeout.
module s32x_sdr_arb #(
   parameter int unsigned NUM_M   = 2,
   parameter int unsigned AW      = 17,
   parameter int unsigned DW      = 16,
   parameter int unsigned RR      = 1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NUM_M*AW-1:0] M_A,
   input  logic [NUM_M*DW-1:0] M_DO,
   input  logic [NUM_M-1:0]    M_CS,
   input  logic [NUM_M*2-1:0]  M_WE,
   input  logic [NUM_M-1:0]    M_RD,
   output logic [NUM_M-1:0]    M_WAIT,
   output logic [DW-1:0]       M_DI,
   output logic [AW-1:0]       SDR_A,
   output logic [DW-1:0]       SDR_DO,
   output logic                SDR_CS,
   output logic [1:0]          SDR_WE,
   output logic                SDR_RD,
   input  logic [DW-1:0]       SDR_DI,
   input  logic                SDR_WAIT,
   output logic                TO_ERR
);

   localparam int unsigned GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic [NUM_M-1:0]  req, arm;
   logic [GW-1:0]     g, last, sel;
   logic              any_req;
   logic [CW-1:0]     cnt;
   logic              timeout_hit;
   logic              active;
   logic [AW-1:0]     lat_a;
   logic [DW-1:0]     lat_do;
   logic [1:0]        lat_we;
   logic              lat_rd;

   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < NUM_M; i++)
         req[i] = M_CS[i] & arm[i] & (M_RD[i] | (|M_WE[2*i +: 2]));
   end

   // Walk the masters starting just past LAST (or from 0 for fixed priority); first hit wins.
   always_comb begin
      int unsigned idx;
      logic [GW-1:0] cand;
      idx     = 0;
      cand    = '0;
      sel     = '0;
      any_req = 1'b0;
      for (int unsigned k = 0; k < NUM_M; k++) begin
         if (RR != 0)
            idx = (32'(last) + 1 + k) % NUM_M;
         else
            idx = k;
         cand = GW'(idx);
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            sel     = cand;
         end
      end
   end

   assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (any_req) state_nxt = ISSUE;
         ISSUE: state_nxt = BUSY;
         BUSY:  if (!SDR_WAIT || timeout_hit) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         M_DI   <= '0;
         TO_ERR <= 1'b0;
         cnt    <= '0;
         g      <= '0;
         last   <= GW'(NUM_M - 1);
         arm    <= '1;
         lat_a  <= '0;
         lat_do <= '0;
         lat_we <= '0;
         lat_rd <= 1'b0;
      end else begin
         TO_ERR <= 1'b0;
         for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!M_CS[i])
               arm[i] <= 1'b1;
            else if (state == DONE && g == GW'(i))
               arm[i] <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (any_req) begin
                  g      <= sel;
                  last   <= sel;
                  cnt    <= '0;
                  lat_a  <= M_A[sel*AW +: AW];
                  lat_do <= M_DO[sel*DW +: DW];
                  lat_we <= M_WE[sel*2 +: 2];
                  lat_rd <= M_RD[sel];
               end
            end
            BUSY: begin
               if (!SDR_WAIT) begin
                  if (lat_rd)
                     M_DI <= SDR_DI;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (timeout_hit) begin
                     M_DI   <= '1;
                     TO_ERR <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign active = (state == ISSUE) || (state == BUSY);
   assign SDR_CS = active;
   assign SDR_A  = active ? lat_a  : '0;
   assign SDR_DO = active ? lat_do : '0;
   assign SDR_WE = active ? lat_we : '0;
   assign SDR_RD = active ? lat_rd : 1'b0;

   always_comb begin
      M_WAIT = '0;
      for (int unsigned i = 0; i < NUM_M; i++)
         M_WAIT[i] = M_CS[i] & ~((state == DONE) && (g == GW'(i)));
   end

endmodule

// File: tb/tb_s32x_sdr_arb.sv
// Directed bench for s32x_sdr_arb: a 2-master round-robin instance and a 4-master
// fixed-priority instance, both with an 8-cycle BUSY timeout.
module tb_s32x_sdr_arb;

   localparam int AW = 17;
   localparam int DW = 16;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 CLK = ~CLK;

   logic [2*AW-1:0] a_ma;
   logic [2*DW-1:0] a_mdo;
   logic [1:0]      a_cs, a_rd, a_wait;
   logic [3:0]      a_we;
   logic [DW-1:0]   a_mdi, a_sdo, a_sdi;
   logic [AW-1:0]   a_sa;
   logic            a_scs, a_srd, a_swait, a_toerr;
   logic [1:0]      a_swe;

   logic [4*AW-1:0] b_ma;
   logic [4*DW-1:0] b_mdo;
   logic [3:0]      b_cs, b_rd, b_wait;
   logic [7:0]      b_we;
   logic [DW-1:0]   b_mdi, b_sdo, b_sdi;
   logic [AW-1:0]   b_sa;
   logic            b_scs, b_srd, b_swait, b_toerr;
   logic [1:0]      b_swe;

   s32x_sdr_arb #(.NUM_M(2), .AW(AW), .DW(DW), .RR(1), .TIMEOUT(8)) dut_a (
      .CLK(CLK), .RST(RST), .M_A(a_ma), .M_DO(a_mdo), .M_CS(a_cs), .M_WE(a_we),
      .M_RD(a_rd), .M_WAIT(a_wait), .M_DI(a_mdi), .SDR_A(a_sa), .SDR_DO(a_sdo),
      .SDR_CS(a_scs), .SDR_WE(a_swe), .SDR_RD(a_srd), .SDR_DI(a_sdi),
      .SDR_WAIT(a_swait), .TO_ERR(a_toerr));

   s32x_sdr_arb #(.NUM_M(4), .AW(AW), .DW(DW), .RR(0), .TIMEOUT(8)) dut_b (
      .CLK(CLK), .RST(RST), .M_A(b_ma), .M_DO(b_mdo), .M_CS(b_cs), .M_WE(b_we),
      .M_RD(b_rd), .M_WAIT(b_wait), .M_DI(b_mdi), .SDR_A(b_sa), .SDR_DO(b_sdo),
      .SDR_CS(b_scs), .SDR_WE(b_swe), .SDR_RD(b_srd), .SDR_DI(b_sdi),
      .SDR_WAIT(b_swait), .TO_ERR(b_toerr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          gcnt;
      int          grants[4];
      logic [1:0]  wl;
      logic        prev_cs;

      a_ma = '0; a_mdo = '0; a_cs = '0; a_rd = '0; a_we = '0; a_sdi = '0; a_swait = 1'b0;
      b_ma = '0; b_mdo = '0; b_cs = '0; b_rd = '0; b_we = '0; b_sdi = '0; b_swait = 1'b0;

      // reset values
      step(); step(); mid();
      chk("rst_scs",   32'(a_scs),   0);
      chk("rst_swe",   32'(a_swe),   0);
      chk("rst_srd",   32'(a_srd),   0);
      chk("rst_sa",    32'(a_sa),    0);
      chk("rst_sdo",   32'(a_sdo),   0);
      chk("rst_mdi",   32'(a_mdi),   0);
      chk("rst_toerr", 32'(a_toerr), 0);
      step(); RST = 1'b0;
      mid();

      // single read, best-case latency
      step();
      a_cs = 2'b01; a_rd = 2'b01; a_ma[0 +: AW] = 17'h01234; a_sdi = 16'hBEEF;
      mid(); chk("rd_t0_scs", 32'(a_scs), 0); chk("rd_t0_wait", 32'(a_wait), 'h1);
      step(); mid();
      chk("rd_iss_scs", 32'(a_scs), 1); chk("rd_iss_sa", 32'(a_sa), 'h01234);
      chk("rd_iss_srd", 32'(a_srd), 1);
      step(); mid();
      chk("rd_busy_scs", 32'(a_scs), 1); chk("rd_busy_wait", 32'(a_wait), 'h1);
      step(); mid();
      chk("rd_done_scs", 32'(a_scs), 0); chk("rd_done_wait", 32'(a_wait), 'h0);
      chk("rd_mdi", 32'(a_mdi), 'hBEEF); chk("rd_toerr", 32'(a_toerr), 0);
      step(); a_cs = '0; a_rd = '0;
      mid(); chk("rd_after_scs", 32'(a_scs), 0);

      // round-robin contention after a fresh reset
      step(); RST = 1'b1;
      step(); RST = 1'b0;
      a_cs = 2'b11; a_rd = 2'b11;
      a_ma[0 +: AW] = 17'h00100; a_ma[AW +: AW] = 17'h00200; a_sdi = 16'h1357;
      gcnt = 0; prev_cs = 1'b0; wl = '0;
      for (int k = 0; k < 16; k++) begin
         mid();
         if (a_scs && !prev_cs) begin
            if (gcnt < 4)
               grants[gcnt] = (a_sa == 17'h00200) ? 1 : ((a_sa == 17'h00100) ? 0 : 9);
            gcnt++;
         end
         prev_cs = a_scs;
         wl = a_cs & ~a_wait;
         step();
         a_cs = ~wl;
      end
      a_cs = '0; a_rd = '0;
      chk("rr_count", 32'(gcnt), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));

      // BUSY timeout
      step();
      a_cs = 2'b01; a_rd = 2'b01; a_ma[0 +: AW] = 17'h0AAAA; a_swait = 1'b1;
      mid(); chk("to_t0_scs", 32'(a_scs), 0);
      n = 0;
      for (int k = 0; k < 30; k++) begin
         step(); mid();
         if (a_scs) n++;
         else break;
      end
      chk("to_cs_cycles", 32'(n), 9);
      chk("to_err", 32'(a_toerr), 1);
      chk("to_mdi", 32'(a_mdi), 'hFFFF);
      chk("to_wait", 32'(a_wait), 'h0);
      step(); a_cs = '0; a_rd = '0; a_swait = 1'b0;
      mid(); chk("to_pulse_end", 32'(a_toerr), 0);

      // byte write by master 1
      step();
      a_cs = 2'b10; a_we = 4'b1000; a_mdo[DW +: DW] = 16'h5A00;
      a_ma[AW +: AW] = 17'h1ABCD; a_sdi = 16'h1111;
      mid(); chk("wr_t0_wait", 32'(a_wait), 'h2);
      step(); mid();
      chk("wr_iss_scs", 32'(a_scs), 1); chk("wr_iss_swe", 32'(a_swe), 'h2);
      chk("wr_iss_sdo", 32'(a_sdo), 'h5A00); chk("wr_iss_sa", 32'(a_sa), 'h1ABCD);
      chk("wr_iss_srd", 32'(a_srd), 0);
      step(); mid();
      chk("wr_busy_swe", 32'(a_swe), 'h2); chk("wr_busy_sdo", 32'(a_sdo), 'h5A00);
      step(); mid();
      chk("wr_done_wait", 32'(a_wait), 'h0); chk("wr_mdi_kept", 32'(a_mdi), 'hFFFF);
      chk("wr_done_swe", 32'(a_swe), 0); chk("wr_done_sdo", 32'(a_sdo), 0);
      step(); a_cs = '0; a_we = '0;

      // reset while BUSY
      step();
      a_cs = 2'b01; a_rd = 2'b01; a_ma[0 +: AW] = 17'h00ABC; a_swait = 1'b1;
      step(); mid(); chk("rb_iss_scs", 32'(a_scs), 1);
      step();
      step(); RST = 1'b1; a_cs = '0; a_rd = '0;
      mid(); chk("rb_busy_scs", 32'(a_scs), 1);
      step(); RST = 1'b0;
      mid();
      chk("rb_scs", 32'(a_scs), 0); chk("rb_toerr", 32'(a_toerr), 0);
      chk("rb_mdi", 32'(a_mdi), 0);
      n = 0;
      for (int k = 0; k < 12; k++) begin
         step(); mid();
         if (a_toerr || a_scs) n++;
      end
      chk("rb_quiet", 32'(n), 0);

      // first grant after reset goes to master 0; dropping CS mid-access completes it
      step();
      a_cs = 2'b11; a_rd = 2'b11; a_ma[AW +: AW] = 17'h00DEF; a_swait = 1'b0; a_sdi = 16'h4321;
      step(); mid(); chk("pr_grant_sa", 32'(a_sa), 'h00ABC);
      step(); a_cs = '0; a_rd = '0;
      mid(); chk("drop_busy_scs", 32'(a_scs), 1);
      step(); mid();
      chk("drop_done_scs", 32'(a_scs), 0); chk("drop_mdi", 32'(a_mdi), 'h4321);

      // fixed priority, 4 masters, masters 1 and 3 requesting
      step();
      b_cs = 4'b1010; b_rd = 4'b1010;
      b_ma[1*AW +: AW] = 17'h00111; b_ma[3*AW +: AW] = 17'h00333; b_sdi = 16'h2222;
      mid(); chk("fp_t0_wait", 32'(b_wait), 'hA);
      step(); mid(); chk("fp_first_sa", 32'(b_sa), 'h00111); chk("fp_first_scs", 32'(b_scs), 1);
      step(); step(); mid();
      chk("fp_done1_wait", 32'(b_wait), 'h8); chk("fp_mdi", 32'(b_mdi), 'h2222);
      step(); mid(); chk("fp_idle_scs", 32'(b_scs), 0);
      step(); mid(); chk("fp_second_sa", 32'(b_sa), 'h00333);
      step(); step(); mid(); chk("fp_done3_wait", 32'(b_wait), 'h2);
      step(); b_cs = '0; b_rd = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
